// File: rtl/priority_scan_pkg.sv
// Shared types for the priority scanner: FSM state encoding and scan-direction codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package priority_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        NONE = 2'd2
    } state_e;

    localparam logic DIR_MSB = 1'b0;
    localparam logic DIR_LSB = 1'b1;

endpackage

// File: rtl/priority_scan_if.sv
// Request/result bundle for priority_scan: vector in, one index beat per set bit out.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface priority_scan_if #(
    parameter int WIDTH = 16,
    parameter int IDXW  = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_vec;
    logic             in_dir;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [IDXW-1:0]  out_idx;
    logic             out_last;
    logic             out_none;
    logic [IDXW:0]    hit_count;

    // Scanner side.
    modport slave (
        input  in_valid, in_vec, in_dir, flush, out_ready,
        output in_ready, out_valid, out_idx, out_last, out_none, hit_count
    );

    // Producer/consumer side.
    modport master (
        output in_valid, in_vec, in_dir, flush, out_ready,
        input  in_ready, out_valid, out_idx, out_last, out_none, hit_count
    );
endinterface

// File: rtl/priority_find.sv
// Combinational priority encoder: picks the highest (MSB-first) or lowest (LSB-first) set bit.
// Latency: 0 cycles, pure combinational.
// Backpressure: none.
module priority_find
    import priority_scan_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]         vec,
    input  logic                     dir,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     any,
    output logic                     single
);
    localparam int IDXW = $clog2(WIDTH);

    // Walk the vector so the winning bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (dir == DIR_LSB) begin
                if (vec[WIDTH-1-i]) idx = IDXW'(WIDTH-1-i);
            end else begin
                if (vec[i]) idx = IDXW'(i);
            end
        end
    end

    assign any    = |vec;
    // Clearing the lowest set bit leaves zero only when exactly one bit was set.
    assign single = any && ((vec & (vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/priority_scan.sv
// Scans a captured vector and emits one index beat per set bit, or a single "none" beat.
// Latency: first beat 1 cycle after acceptance; then one beat per cycle while out_ready is high.
// Backpressure: beats hold stable under out_ready=0; no new vector is accepted until the scan ends.
module priority_scan
    import priority_scan_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    priority_scan_if.slave bus
);
    localparam logic [IDXW:0] HIT_MAX = (IDXW+1)'(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             dir_q, dir_d;
    logic [IDXW:0]    hit_q, hit_d;

    logic [IDXW-1:0]  find_idx;
    logic             find_any;
    logic             find_single;
    logic             scan_act;
    logic             none_act;

    priority_find #(.WIDTH(WIDTH)) u_find (
        .vec    (mask_q),
        .dir    (dir_q),
        .idx    (find_idx),
        .any    (find_any),
        .single (find_single)
    );

    assign scan_act = (state_q == SCAN) && find_any;
    assign none_act = (state_q == NONE);

    // Next-state: capture in IDLE, retire one bit per handshake in SCAN, flush beats a handshake.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        dir_d   = dir_q;
        hit_d   = hit_q;
        case (state_q)
            IDLE: begin
                // flush is meaningless here; a concurrent request is still taken.
                if (bus.in_valid) begin
                    mask_d  = bus.in_vec;
                    dir_d   = bus.in_dir;
                    hit_d   = '0;
                    state_d = (|bus.in_vec) ? SCAN : NONE;
                end
            end
            SCAN: begin
                if (bus.flush) begin
                    state_d = IDLE;
                    mask_d  = '0;
                end else if (bus.out_ready && find_any) begin
                    mask_d = mask_q & ~(WIDTH'(1) << find_idx);
                    if (hit_q != HIT_MAX) hit_d = hit_q + 1'b1;
                    if (find_single) state_d = IDLE;
                end
            end
            NONE: begin
                if (bus.flush) begin
                    state_d = IDLE;
                    mask_d  = '0;
                end else if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                mask_d  = '0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mask_q  <= '0;
            dir_q   <= DIR_MSB;
            hit_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            dir_q   <= dir_d;
            hit_q   <= hit_d;
        end
    end

    // Outputs come only from registered state and the encoder; reset forces everything low.
    assign bus.in_ready  = rst_n && (state_q == IDLE);
    assign bus.out_valid = rst_n && (scan_act || none_act);
    assign bus.out_idx   = (rst_n && scan_act) ? find_idx : '0;
    assign bus.out_last  = rst_n && (none_act || (scan_act && find_single));
    assign bus.out_none  = rst_n && none_act;
    assign bus.hit_count = rst_n ? hit_q : '0;

endmodule

// File: tb/tb_priority_scan.sv
// Randomised and directed bench for priority_scan against a queue-based reference model.
// Latency: checks first beat one cycle after acceptance and one-cycle beats under full ready.
// Backpressure: exercises random/alternating out_ready stalls, flush and mid-scan reset.
module tb_priority_scan;
    localparam int W  = 16;
    localparam int IW = $clog2(W);

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_bad;

    priority_scan_if #(.WIDTH(W)) bus ();

    priority_scan #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ovld"}, bus.out_valid, 0);
        chk({tag, "_idx"},  bus.out_idx,   0);
        chk({tag, "_last"}, bus.out_last,  0);
        chk({tag, "_none"}, bus.out_none,  0);
    endtask

    // rdy_pct < 0 means out_ready alternates 1,0,1,0 starting with 1.
    // abort_kind: 0 none, 1 flush (with out_ready=1) while beat abort_beat is shown, 2 reset then.
    task automatic run_vec(input logic [W-1:0] vec, input logic d, input int rdy_pct,
                           input int abort_beat, input int abort_kind);
        int  q[$];
        int  nbits;
        int  beats;
        int  hits;
        int  cyc;
        bit  done;
        bit  aborted;
        bit  rdy;
        // Reference: list of set-bit indices in the requested scan order.
        q = {};
        for (int k = 0; k < W; k++) begin
            int b;
            b = d ? k : W - 1 - k;
            if (vec[b]) q.push_back(b);
        end
        nbits = q.size();

        cyc = 0;
        while (!bus.in_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("in_ready_wait", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_vec   = vec;
        bus.in_dir   = d;
        bus.flush    = 1'($urandom_range(1));   // ignored while idle
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.in_vec   = W'($urandom);
        bus.in_dir   = 1'($urandom_range(1));

        beats = 0; hits = 0; cyc = 0; done = 0; aborted = 0;
        while (!done && cyc < 300) begin
            cyc++;
            chk("out_valid", bus.out_valid, 1);
            chk("in_ready_busy", bus.in_ready, 0);
            chk("hit_run", bus.hit_count, hits);
            if (nbits == 0) begin
                chk("none_flag", bus.out_none, 1);
                chk("none_last", bus.out_last, 1);
                chk("none_idx",  bus.out_idx,  0);
            end else begin
                chk("idx",  bus.out_idx,  q[0]);
                chk("last", bus.out_last, q.size() == 1);
                chk("none", bus.out_none, 0);
            end
            rdy = (rdy_pct < 0) ? cyc[0] : ($urandom_range(99) < rdy_pct);
            if (abort_kind != 0 && beats + 1 == abort_beat) begin
                done = 1; aborted = 1;
                if (abort_kind == 1) begin
                    bus.flush = 1'b1;
                    bus.out_ready = 1'b1;
                    @(negedge clk);
                    bus.flush = 1'b0;
                    bus.out_ready = 1'b0;
                    chk("flush_ovld", bus.out_valid, 0);
                    chk("flush_irdy", bus.in_ready, 1);
                    chk("flush_hit", bus.hit_count, hits);
                    @(negedge clk);
                    chk("flush_hold", bus.hit_count, hits);
                    chk("flush_ovld2", bus.out_valid, 0);
                end else begin
                    bus.out_ready = 1'b1;
                    rst_n = 1'b0;
                    #1;
                    chk_quiet("rst_comb");
                    chk("rst_comb_irdy", bus.in_ready, 0);
                    @(negedge clk);
                    bus.out_ready = 1'b0;
                    chk_quiet("rst_edge");
                    chk("rst_edge_irdy", bus.in_ready, 0);
                    chk("rst_edge_hit", bus.hit_count, 0);
                    rst_n = 1'b1;
                    for (int k = 0; k < 3; k++) begin
                        @(negedge clk);
                        chk("rst_after_ovld", bus.out_valid, 0);
                        chk("rst_after_irdy", bus.in_ready, 1);
                        chk("rst_after_hit", bus.hit_count, 0);
                    end
                end
            end else begin
                bus.out_ready = rdy;
                @(negedge clk);
                bus.out_ready = 1'b0;
                if (rdy) begin
                    beats++;
                    if (nbits == 0) begin
                        done = 1;
                    end else begin
                        void'(q.pop_front());
                        hits++;
                        if (q.size() == 0) done = 1;
                    end
                end
            end
        end
        if (!done) chk("timeout", 0, 1);
        if (!aborted) begin
            chk("end_ovld", bus.out_valid, 0);
            chk("end_irdy", bus.in_ready, 1);
            chk("end_hit", bus.hit_count, hits);
            if (rdy_pct == 100) chk("cycles", cyc, (nbits == 0) ? 1 : nbits);
        end
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_vec    = '0;
        bus.in_dir    = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b1;          // request during reset must not be taken
        bus.in_vec   = 16'h1234;
        #1;
        chk_quiet("reset");
        chk("reset_irdy", bus.in_ready, 0);
        chk("reset_hit", bus.hit_count, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_irdy", bus.in_ready, 1);
        chk("post_reset_ovld", bus.out_valid, 0);
        chk("post_reset_hit", bus.hit_count, 0);

        // Directed cases.
        run_vec(16'h8001, 1'b0, 100, 0, 0);
        run_vec(16'h8001, 1'b1, 100, 0, 0);
        run_vec(16'h0000, 1'b0, 100, 0, 0);
        run_vec(16'hFFFF, 1'b0, -1,  0, 0);
        run_vec(16'h00F0, 1'b1, 100, 2, 1);
        run_vec(16'h0F00, 1'b0, 100, 3, 2);
        run_vec(16'h0000, 1'b1, 30,  1, 1);

        // Random traffic.
        for (int n = 0; n < 150; n++) begin
            logic [W-1:0] v;
            int sel, pct, ab, kind, nb;
            sel = $urandom_range(3);
            case (sel)
                0: v = '0;
                1: v = W'(1) << $urandom_range(W - 1);
                2: v = W'($urandom) & W'($urandom);
                default: v = W'($urandom);
            endcase
            pct  = (n % 5 == 0) ? 100 : $urandom_range(20, 100);
            nb   = $countones(v);
            kind = 0;
            ab   = 0;
            if ($urandom_range(7) == 0) begin
                kind = ($urandom_range(3) == 0) ? 2 : 1;
                ab   = $urandom_range(1, (nb == 0) ? 1 : nb);
            end
            run_vec(v, 1'($urandom_range(1)), pct, ab, kind);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
